tx_byte_ctrl: RTL and testbench
===============================

# tx_byte_ctrl

Transmit byte sequencer sitting directly upstream of the 8-bit MSB-first transmit shift register. Accepts bytes over a valid/ready handshake into a one-entry holding register and drives the shift register's parallel data, load strobe, shift enable and bit-period strobe. Produces a fixed bit period of CLKS_PER_BIT clocks and sends back-to-back bytes without gaps when the next byte is already held.

## Interface
- CLKS_PER_BIT, 8: clocks per serial bit; legal range 2..255.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- byte_valid  input  1  upstream has a byte on byte_data.
- byte_data  input  8  byte to transmit, MSB sent first.
- byte_ready  output  1  holding register empty (= !hold_full); handshake completes when byte_valid & byte_ready at a rising edge.
- tx_data  output  8  holding register contents; feeds the shift register's parallel input.
- load_data  output  1  one-cycle pulse: shift register loads tx_data.
- tx_enable  output  1  high while in SHIFT.
- bit_strobe  output  1  one-cycle pulse at the end of each bit period; drives the shift register's falling_edge_found.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when the final byte of a burst finishes.
- sent_count  output  8  bytes completed since reset; wraps 255 -> 0.

## Operation
- Holding register: hold_data[7:0], hold_full. Set on handshake; cleared in any cycle where load_data = 1. Handshake and clear never coincide, because byte_ready = 0 while hold_full = 1.
- Counters: clk_cnt, width $clog2(CLKS_PER_BIT), range 0..CLKS_PER_BIT-1; bit_cnt, 3 bits, range 0..7.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE: tx_enable = 0. If hold_full, go to LOAD.
- LOAD: load_data = 1 for exactly one cycle; hold_full clears; clk_cnt and bit_cnt are zeroed; go to SHIFT.
- SHIFT: tx_enable = 1. clk_cnt increments each cycle.
- SHIFT, when clk_cnt == CLKS_PER_BIT-1 and bit_cnt < 7: bit_strobe = 1, bit_cnt increments, clk_cnt returns to 0.
- SHIFT, when clk_cnt == CLKS_PER_BIT-1 and bit_cnt == 7 (end of byte):
  - No bit_strobe is issued.
  - sent_count increments.
  - If hold_full: load_data = 1 this cycle, hold clears, counters zero, stay in SHIFT (seamless reload).
  - Otherwise: done = 1, go to IDLE.
- Only 7 strobes are issued per byte. The MSB is visible from the load until the first strobe, so each of the 8 bits occupies exactly CLKS_PER_BIT cycles.
- bit_strobe and load_data are mutually exclusive.
- bit_strobe is never high while tx_enable = 0.

## Timing
- Reset values: state IDLE; hold_full 0; hold_data 0; tx_data 0; counters 0; sent_count 0; byte_ready 1; load_data, tx_enable, bit_strobe, busy, done all 0.
- Handshake in cycle c (IDLE, empty): hold_full = 1 in c+1; LOAD (load_data = 1) in c+2; SHIFT from c+3.
- Strobes in cycles c+2+k*CLKS_PER_BIT, k = 1..7. End of byte in c+2+8*CLKS_PER_BIT.
- Byte period: exactly 8*CLKS_PER_BIT cycles, load-to-load, when back-to-back.
- byte_ready returns to 1 in the cycle after any load_data pulse. A new byte may be accepted at any time during SHIFT.
- done and tx_enable: done pulses in the last SHIFT cycle; tx_enable falls the next cycle.
- rst asserted mid-byte: all state returns to reset values immediately and the held byte is discarded. After rst deasserts, nothing is transmitted until a new handshake.
- byte_valid held high while byte_ready = 0: no effect, and byte_data is not sampled.

## Test plan
- Reset: assert rst mid-SHIFT (bit_cnt = 3) -> outputs return to reset values that cycle, byte_ready = 1, no further strobes, sent_count = 0.
- Single byte, CLKS_PER_BIT = 8, byte 0xA5 at cycle c:
  - load_data in c+2, tx_data = 0xA5.
  - 7 strobes at c+10, c+18, …, c+58.
  - done at c+66, then IDLE; sent_count = 1.
  - Serial line from the downstream shift register reads 1,0,1,0,0,1,0,1, 8 cycles each.
- Back-to-back 0x3C then 0xC3, second byte offered during the first byte's SHIFT:
  - Second handshake completes immediately.
  - Reload load_data at c+66 with tx_data = 0xC3; no gap and no done at c+66.
  - done at c+130; sent_count = 2.
- Backpressure: hold a byte while SHIFT is active, then drive a third byte_valid -> byte_ready = 0 until the reload pulse, and the third byte is not captured early.
- CLKS_PER_BIT = 2, burst of 256 bytes -> every byte period is 16 cycles, sent_count wraps to 0, exactly one done at the end.
- Checker on every cycle: load_data & bit_strobe never both high; bit_strobe implies tx_enable; exactly 7 strobes between consecutive load_data pulses.

Source files
------------

// File: rtl/tx_byte_ctrl.sv
// rtl/tx_byte_ctrl.sv - transmit byte sequencer driving an 8-bit MSB-first shift register
//
// Purpose: accepts bytes over valid/ready into a one-entry holding register and
// sequences load, shift-enable and bit-period strobes for the downstream shift
// register. Back-to-back bytes are reloaded with no idle gap.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   byte_valid  upstream byte present on byte_data
//   byte_data   byte to transmit, MSB first
//   byte_ready  holding register empty
//   tx_data     holding register contents (shift register parallel input)
//   load_data   one-cycle pulse: shift register loads tx_data
//   tx_enable   high while shifting
//   bit_strobe  one-cycle pulse at the end of each bit period
//   busy        sequencer not idle
//   done        one-cycle pulse when the last byte of a burst finishes
//   sent_count  bytes completed since reset, wrapping
module tx_byte_ctrl #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic [7:0] tx_data,
  output logic       load_data,
  output logic       tx_enable,
  output logic       bit_strobe,
  output logic       busy,
  output logic       done,
  output logic [7:0] sent_count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      sent_count_q, sent_count_d;

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    sent_count_d = sent_count_q;
    load_data    = 1'b0;
    tx_enable    = 1'b0;
    bit_strobe   = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        load_data = 1'b1;
        clk_cnt_d = '0;
        bit_cnt_d = 3'd0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        tx_enable = 1'b1;
        clk_cnt_d = clk_cnt_q + CW'(1);
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          if (bit_cnt_q != 3'd7) begin
            bit_strobe = 1'b1;
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end else begin
            // End of byte: the MSB was already on the line from the load, so
            // only 7 strobes were needed. Reload in place if a byte is waiting.
            sent_count_d = sent_count_q + 8'd1;
            bit_cnt_d    = 3'd0;
            if (hold_full_q) begin
              load_data = 1'b1;
            end else begin
              done    = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // byte_ready is low whenever the register is full, so a load (which needs a
  // full register) can never coincide with a new handshake.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (load_data) begin
      hold_full_d = 1'b0;
    end else if (byte_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = byte_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_full_q  <= 1'b0;
      hold_data_q  <= 8'd0;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= 3'd0;
      sent_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign byte_ready = ~hold_full_q;
  assign tx_data    = hold_data_q;
  assign busy       = (state_q != S_IDLE);
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_tx_byte_ctrl.sv
// tb/tb_tx_byte_ctrl.sv - scoreboard bench for tx_byte_ctrl at CLKS_PER_BIT 8 and 2
module tb_tx_byte_ctrl;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       byte_valid;
  logic [1:0][7:0]  byte_data;
  logic [1:0]       byte_ready;
  logic [1:0][7:0]  tx_data;
  logic [1:0]       load_data;
  logic [1:0]       tx_enable;
  logic [1:0]       bit_strobe;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0][7:0]  sent_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t load_q [2][$];
  exp_t done_q [2][$];
  bit   pend [2];
  int   prev_end [2];
  int   nsent [2];

  bit   last_valid [2];
  int   last_load [2];
  int   strobe_cnt [2];
  int   cur_exp [2];
  int   sc_chk [2];
  int   dones_seen [2];
  logic [7:0] sr;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tx_byte_ctrl #(.CLKS_PER_BIT(g == 0 ? 8 : 2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid[g]),
      .byte_data  (byte_data[g]),
      .byte_ready (byte_ready[g]),
      .tx_data    (tx_data[g]),
      .load_data  (load_data[g]),
      .tx_enable  (tx_enable[g]),
      .bit_strobe (bit_strobe[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .sent_count (sent_count[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream MSB-first shift register fed by instance 0.
  always @(posedge clk or posedge rst) begin
    if (rst) sr <= 8'd0;
    else if (load_data[0]) sr <= tx_data[0];
    else if (bit_strobe[0]) sr <= {sr[6:0], 1'b0};
  end

  function automatic int cpb(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void clear_model(input int i);
    load_q[i].delete();
    done_q[i].delete();
    pend[i]     = 1'b0;
    prev_end[i] = 0;
    nsent[i]    = 0;
  endfunction

  // Offer a byte; returns the cycle in which the handshake completed.
  task automatic send(input int i, input logic [7:0] d, output int c);
    bit ok;
    exp_t e;
    int   l;
    ok = 1'b0;
    byte_valid[i] = 1'b1;
    byte_data[i]  = d;
    for (int k = 0; k < 3000; k++) begin
      if (byte_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    c = cyc;
    @(posedge clk);
    #1;
    byte_valid[i] = 1'b0;
    l = (pend[i] && prev_end[i] >= c + 1) ? prev_end[i] : c + 2;
    if (pend[i] && l != prev_end[i]) begin
      e.cyc = prev_end[i];
      e.val = nsent[i] & 255;
      done_q[i].push_back(e);
    end
    e.cyc = l;
    e.val = d;
    load_q[i].push_back(e);
    nsent[i]++;
    pend[i]     = 1'b1;
    prev_end[i] = l + 8 * cpb(i);
  endtask

  task automatic wait_idle(input int i);
    exp_t e;
    bit   ok;
    if (pend[i]) begin
      e.cyc = prev_end[i];
      e.val = nsent[i] & 255;
      done_q[i].push_back(e);
      pend[i] = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (load_q[i].size() == 0 && done_q[i].size() == 0 && !busy[i] && sc_chk[i] < 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic check_reset_outputs(input int i);
    chk("rst_byte_ready", byte_ready[i], 1);
    chk("rst_tx_data", tx_data[i], 0);
    chk("rst_load_data", load_data[i], 0);
    chk("rst_tx_enable", tx_enable[i], 0);
    chk("rst_bit_strobe", bit_strobe[i], 0);
    chk("rst_busy", busy[i], 0);
    chk("rst_done", done[i], 0);
    chk("rst_sent_count", sent_count[i], 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_model(0);
    clear_model(1);
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a load or done.
  initial begin
    exp_t e;
    int   j;
    for (int i = 0; i < 2; i++) begin
      last_valid[i] = 1'b0;
      sc_chk[i]     = -1;
      strobe_cnt[i] = 0;
      dones_seen[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          last_valid[i] = 1'b0;
          sc_chk[i]     = -1;
          strobe_cnt[i] = 0;
          continue;
        end
        if (sc_chk[i] >= 0) begin
          chk("sent_count_after_done", sent_count[i], sc_chk[i]);
          sc_chk[i] = -1;
        end
        if (load_data[i] || bit_strobe[i])
          chk("load_strobe_exclusive", int'(load_data[i] & bit_strobe[i]), 0);
        if (bit_strobe[i]) begin
          chk("strobe_needs_enable", tx_enable[i], 1);
          if (!last_valid[i]) begin
            chk("strobe_without_load", 1, 0);
          end else begin
            strobe_cnt[i]++;
            chk("strobe_cycle", cyc, last_load[i] + strobe_cnt[i] * cpb(i));
          end
        end
        if (i == 0 && tx_enable[0] && last_valid[0] && cyc > last_load[0]) begin
          j = (cyc - last_load[0] - 1) / 8;
          if (j < 8) chk("serial_bit", sr[7], (cur_exp[0] >> (7 - j)) & 1);
        end
        if (load_data[i]) begin
          if (last_valid[i]) chk("strobes_per_byte", strobe_cnt[i], 7);
          if (load_q[i].size() == 0) begin
            chk("unexpected_load", 1, 0);
            cur_exp[i] = tx_data[i];
          end else begin
            e = load_q[i].pop_front();
            chk("load_cycle", cyc, e.cyc);
            chk("load_tx_data", tx_data[i], e.val);
            cur_exp[i] = e.val;
          end
          last_valid[i] = 1'b1;
          last_load[i]  = cyc;
          strobe_cnt[i] = 0;
        end
        if (done[i]) begin
          dones_seen[i]++;
          chk("strobes_before_done", strobe_cnt[i], 7);
          if (done_q[i].size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = done_q[i].pop_front();
            chk("done_cycle", cyc, e.cyc);
            sc_chk[i] = e.val;
          end
          last_valid[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int c, c0, c2, c3;
    rst        = 1'b1;
    byte_valid = '0;
    byte_data  = '0;
    clear_model(0);
    clear_model(1);
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Single byte 0xA5: load c+2, strobes c+10..c+58, done c+66.
    @(negedge clk);
    send(0, 8'hA5, c);
    wait_idle(0);
    chk("single_sent_count", sent_count[0], 1);
    chk("single_busy", busy[0], 0);

    // Back-to-back 0x3C then 0xC3 with seamless reload at c+66.
    do_reset();
    send(0, 8'h3C, c);
    repeat (20) @(negedge clk);
    c0 = cyc;
    send(0, 8'hC3, c2);
    chk("b2b_immediate_accept", c2, c0);
    wait_idle(0);
    chk("b2b_sent_count", sent_count[0], 2);

    // Backpressure: third byte waits until the cycle after the reload.
    send(0, 8'h11, c);
    repeat (5) @(negedge clk);
    send(0, 8'h22, c2);
    send(0, 8'h33, c3);
    chk("bp_accept_cycle", c3 - c, 67);
    wait_idle(0);
    chk("bp_sent_count", sent_count[0], 5);

    // Reset mid-byte after three strobes: held byte discarded, nothing follows.
    @(negedge clk);
    send(0, 8'h5A, c);
    while (cyc < c + 30) @(negedge clk);
    chk("mid_strobes_before_rst", strobe_cnt[0], 3);
    do_reset();
    repeat (100) @(negedge clk);
    chk("post_rst_sent_count", sent_count[0], 0);
    chk("post_rst_busy", busy[0], 0);

    // Burst of 256 bytes at CLKS_PER_BIT = 2.
    dones_seen[1] = 0;
    for (int k = 0; k < 256; k++) begin
      send(1, 8'(k) ^ 8'h5A, c);
    end
    wait_idle(1);
    chk("burst_sent_count_wrap", sent_count[1], 0);
    chk("burst_single_done", dones_seen[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
